uart_rx_ext: RTL
================

UART_RX_EXT -- requirements
Module: uart_rx_ext

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal 5..8.
REQ-002 SHALL have parameter PARITY_EN, default 0; 1 = parity bit present after data.
REQ-003 SHALL have parameter PARITY_ODD, default 0; 0 = even, 1 = odd; ignored when PARITY_EN=0.
REQ-004 SHALL have parameter STOP_BITS, default 1, legal 1 or 2.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, power of two, 2..64.
REQ-006 SHALL have port clk_i  input  1  system clock; all logic on rising edge.
REQ-007 SHALL have port rst_n_i  input  1  asynchronous active-low reset.
REQ-008 SHALL have port brg_stb_i  input  1  one-cycle strobe at 16x baud.
REQ-009 SHALL have port din_i  input  1  asynchronous serial line, idle high.
REQ-010 SHALL have port rd_i  input  1  pop head FIFO entry.
REQ-011 SHALL have port clr_ovr_i  input  1  clear sticky overrun flag.
REQ-012 SHALL have port dout_o  output  DATA_BITS  head entry data, first-word fall-through.
REQ-013 SHALL have port valid_o  output  1  FIFO non-empty.
REQ-014 SHALL have port frame_err_o  output  1  head entry stop-bit error.
REQ-015 SHALL have port parity_err_o  output  1  head entry parity error.
REQ-016 SHALL have port overrun_o  output  1  sticky: word lost to full FIFO.
REQ-017 SHALL have port done_stb_o  output  1  one-cycle pulse per word pushed.

Function
REQ-018 din_i SHALL pass a 2-flop synchroniser (flops reset to 1) before any use.
REQ-019 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; sample counter 0..15 advances only on brg_stb_i.
REQ-020 IDLE SHALL arm start detection only after seeing synchronised line = 1; falling edge then enters START with counter cleared.
REQ-021 START SHALL re-sample at counter 7 (mid-bit); line high -> false start, return to IDLE with no push.
REQ-022 Each subsequent bit SHALL be 16 strobes; bit value = majority of samples at counter 7, 8, 9.
REQ-023 Data SHALL be received LSB first into a DATA_BITS shift register; bit counter width ceil(log2(DATA_BITS+1)).
REQ-024 PARITY state SHALL occur only if PARITY_EN; error when XOR(data, parity bit) != PARITY_ODD.
REQ-025 STOP SHALL check STOP_BITS stop bits; any sampled 0 sets frame error for the word.
REQ-026 At the majority decision of the last stop bit the word {data, fe, pe} SHALL be pushed and FSM return to IDLE (half-bit early resync).
REQ-027 done_stb_o SHALL pulse exactly one cycle, the cycle after a successful push.
REQ-028 valid_o SHALL rise the cycle after push into an empty FIFO.
REQ-029 rd_i with FIFO empty SHALL be ignored.
REQ-030 Push when full SHALL drop the word, set overrun_o, suppress done_stb_o; entries unchanged.
REQ-031 Push and rd_i in the same cycle when full SHALL pop then push; no overrun.
REQ-032 clr_ovr_i SHALL clear overrun_o; simultaneous clear and new overrun SHALL leave overrun_o = 1.
REQ-033 FIFO pointers SHALL wrap modulo FIFO_DEPTH with an extra bit for full/empty distinction.
REQ-034 With FIFO empty, dout_o, frame_err_o, parity_err_o SHALL be 0.

Reset
REQ-035 rst_n_i low SHALL immediately force IDLE (disarmed), counters 0, FIFO empty, all outputs 0, synchroniser flops 1.
REQ-036 Reset mid-frame SHALL discard the partial word; reception resumes only after line seen high.

Structure
REQ-037 Shared package uart_pkg SHALL hold the FSM state encoding, OVERSAMPLE=16, and sample-point constants 7/8/9.
REQ-038 FIFO SHALL be a sub-module uart_fifo (parametrised width/depth, sync, FWFT); FSM and sampling stay in uart_rx_ext.

Verification
REQ-039 Defaults, existing UART transmitter sends 0x75, brg_stb_i = clk/4 -> one done_stb_o, dout_o=0x75, fe=0, pe=0, valid_o until rd_i.
REQ-040 DATA_BITS=7, PARITY_EN=1 even; frame 0x35 with parity bit inverted -> dout_o=0x35, parity_err_o=1.
REQ-041 Stop bit driven 0 for frame 0xA5 -> dout_o=0xA5, frame_err_o=1; line held low afterwards -> no further word until high.
REQ-042 din_i low for 4 strobes then high -> no push, FSM back in IDLE, next valid frame 0x5A received correctly.
REQ-043 FIFO_DEPTH=4, send 0x01..0x05 without reads -> overrun_o=1, pops return 0x01..0x04 then valid_o=0; clr_ovr_i clears.
REQ-044 rst_n_i pulsed low mid-data of 0xFF -> valid_o=0, no done_stb_o; following 0x3C received intact.

Source files
------------

// File: rtl/uart_pkg.sv
// UART receiver shared definitions.
// FSM encoding, oversampling and sample-point constants.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    localparam int OVERSAMPLE = 16;

    localparam logic [3:0] SMP_A   = 4'd7;
    localparam logic [3:0] SMP_B   = 4'd8;
    localparam logic [3:0] SMP_C   = 4'd9;
    localparam logic [3:0] CNT_MAX = 4'(OVERSAMPLE - 1);

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous first-word fall-through FIFO for received words.
// Extra pointer bit separates full from empty.
module uart_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             empty;
    logic             do_pop;
    logic             do_push;

    assign empty   = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop_i & ~empty;
    assign do_push = push_i & (~full_o | do_pop);
    assign valid_o = ~empty;
    assign data_o  = empty ? '0 : mem[rptr_q[AW-1:0]];

    // Pointer update; pop is applied before push so a full FIFO can take a word.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage write; contents need no reset since empty masks the output.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/uart_rx_ext.sv
// 16x oversampling UART receiver with majority voting,
// optional parity, 1/2 stop bits and an output FIFO.
module uart_rx_ext
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 brg_stb_i,
    input  logic                 din_i,
    input  logic                 rd_i,
    input  logic                 clr_ovr_i,
    output logic [DATA_BITS-1:0] dout_o,
    output logic                 valid_o,
    output logic                 frame_err_o,
    output logic                 parity_err_o,
    output logic                 overrun_o,
    output logic                 done_stb_o
);

    localparam int BCW = $clog2(DATA_BITS + 1);
    localparam int WW  = DATA_BITS + 2;

    localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_BITS);
    localparam logic           STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic           ODD       = 1'(PARITY_ODD);
    localparam logic           HAS_PAR   = (PARITY_EN != 0);

    logic [1:0]           sync_q;
    logic                 rx;

    rx_state_e            state_q, state_n;
    logic [3:0]           cnt_q, cnt_n;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_n;
    logic [DATA_BITS-1:0] shreg_q, shreg_n;
    logic                 s7_q, s7_n;
    logic                 s8_q, s8_n;
    logic                 fe_q, fe_n;
    logic                 par_q, par_n;
    logic                 armed_q, armed_n;
    logic                 stop_cnt_q, stop_cnt_n;

    logic                 bit_val;
    logic                 dec;
    logic                 wrap;
    logic                 push;
    logic                 push_fe;
    logic                 push_pe;
    logic [WW-1:0]        push_word;
    logic [WW-1:0]        head;
    logic                 full;
    logic                 pop_ok;
    logic                 push_ok;
    logic                 ovr_q;
    logic                 done_q;

    assign rx      = sync_q[1];
    assign bit_val = maj3(s7_q, s8_q, rx);
    assign dec     = brg_stb_i && (cnt_q == SMP_C);
    assign wrap    = brg_stb_i && (cnt_q == CNT_MAX);
    assign push_fe = fe_q | ~bit_val;
    assign push_pe = HAS_PAR && ((^shreg_q ^ par_q) != ODD);

    // Two-flop synchroniser; idles high so reset does not fake a start edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) sync_q <= 2'b11;
        else          sync_q <= {sync_q[0], din_i};
    end

    // Receiver FSM and datapath registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            s7_q       <= 1'b1;
            s8_q       <= 1'b1;
            fe_q       <= 1'b0;
            par_q      <= 1'b0;
            armed_q    <= 1'b0;
            stop_cnt_q <= 1'b0;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            bit_cnt_q  <= bit_cnt_n;
            shreg_q    <= shreg_n;
            s7_q       <= s7_n;
            s8_q       <= s8_n;
            fe_q       <= fe_n;
            par_q      <= par_n;
            armed_q    <= armed_n;
            stop_cnt_q <= stop_cnt_n;
        end
    end

    // Next-state logic: bit timing, majority sampling and word assembly.
    always_comb begin
        state_n    = state_q;
        cnt_n      = cnt_q;
        bit_cnt_n  = bit_cnt_q;
        shreg_n    = shreg_q;
        s7_n       = s7_q;
        s8_n       = s8_q;
        fe_n       = fe_q;
        par_n      = par_q;
        armed_n    = armed_q;
        stop_cnt_n = stop_cnt_q;
        push       = 1'b0;

        if (brg_stb_i) begin
            cnt_n = cnt_q + 4'd1;
            if (cnt_q == SMP_A) s7_n = rx;
            if (cnt_q == SMP_B) s8_n = rx;
        end

        unique case (state_q)
            ST_IDLE: begin
                cnt_n = '0;
                if (rx) begin
                    armed_n = 1'b1;
                end else if (armed_q) begin
                    armed_n = 1'b0;
                    state_n = ST_START;
                end
            end
            ST_START: begin
                fe_n = 1'b0;
                if (brg_stb_i && cnt_q == SMP_A && rx) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else if (wrap) begin
                    state_n   = ST_DATA;
                    bit_cnt_n = '0;
                end
            end
            ST_DATA: begin
                if (dec) begin
                    shreg_n   = {bit_val, shreg_q[DATA_BITS-1:1]};
                    bit_cnt_n = bit_cnt_q + 1'b1;
                end
                if (wrap && bit_cnt_q == BIT_LAST) begin
                    state_n    = HAS_PAR ? ST_PARITY : ST_STOP;
                    stop_cnt_n = 1'b0;
                end
            end
            ST_PARITY: begin
                if (dec)  par_n   = bit_val;
                if (wrap) state_n = ST_STOP;
            end
            ST_STOP: begin
                if (dec) begin
                    if (!bit_val) fe_n = 1'b1;
                    if (stop_cnt_q == STOP_LAST) begin
                        push    = 1'b1;
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                    end else begin
                        stop_cnt_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign push_word = {shreg_q, push_fe, push_pe};
    assign pop_ok    = rd_i & valid_o;
    assign push_ok   = push & (~full | pop_ok);

    uart_fifo #(
        .WIDTH (WW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (push),
        .data_i  (push_word),
        .pop_i   (rd_i),
        .data_o  (head),
        .valid_o (valid_o),
        .full_o  (full)
    );

    // Sticky overrun and push-done pulse; a new overrun beats a clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ovr_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= push_ok;
            if (push && !push_ok) ovr_q <= 1'b1;
            else if (clr_ovr_i)   ovr_q <= 1'b0;
        end
    end

    assign dout_o       = head[WW-1:2];
    assign frame_err_o  = head[1];
    assign parity_err_o = head[0];
    assign overrun_o    = ovr_q;
    assign done_stb_o   = done_q;

endmodule
